// File: rtl/writeback_commit.sv
// rtl/writeback_commit.sv - per-unit result queues, round-robin retirement to register file and scoreboard release
module writeback_commit #(
    parameter int NUM_UNITS  = 4,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_UNITS-1:0]             unit_valid,
    output logic [NUM_UNITS-1:0]             unit_ready,
    input  logic [NUM_UNITS*REG_ADDR_W-1:0]  unit_rd,
    input  logic [NUM_UNITS*XLEN-1:0]        unit_data,
    input  logic                             commit_en,
    output logic                             rf_we,
    output logic [REG_ADDR_W-1:0]            rf_addr,
    output logic [XLEN-1:0]                  rf_data,
    output logic                             rel_write,
    output logic [REG_ADDR_W-1:0]            rel_address,
    output logic                             idle
);
    localparam int PTR_W = $clog2(NUM_UNITS);
    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int CW    = AW + 1;

    logic [REG_ADDR_W-1:0] r_q_rd   [NUM_UNITS][BUF_DEPTH];
    logic [XLEN-1:0]       r_q_data [NUM_UNITS][BUF_DEPTH];
    logic [AW-1:0]         r_wr_ptr [NUM_UNITS];
    logic [AW-1:0]         r_rd_ptr [NUM_UNITS];
    logic [CW-1:0]         r_count  [NUM_UNITS];
    logic [CW-1:0]         w_count_next [NUM_UNITS];
    logic [NUM_UNITS-1:0]  r_ready;
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [NUM_UNITS-1:0]  w_push;
    logic [NUM_UNITS-1:0]  w_pop;
    logic [NUM_UNITS-1:0]  w_nonempty;
    logic                  w_grant_vld;
    logic [PTR_W-1:0]      w_grant;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;

    assign unit_ready = r_ready;
    assign w_push     = unit_valid & r_ready;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_nonempty[i]   = (r_count[i] != '0);
            w_count_next[i] = r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        end
    end

    // First non-empty queue at or after the round-robin pointer, with wrap.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_pop       = '0;
        if (commit_en) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                idx = (int'(r_rr_ptr) + k) % NUM_UNITS;
                if (!w_grant_vld && w_nonempty[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = PTR_W'(idx);
                end
            end
        end
        if (w_grant_vld) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    assign w_head_rd   = r_q_rd[w_grant][r_rd_ptr[w_grant]];
    assign w_head_data = r_q_data[w_grant][r_rd_ptr[w_grant]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_push[i]) begin
                r_q_rd[i][r_wr_ptr[i]]   <= unit_rd[i*REG_ADDR_W +: REG_ADDR_W];
                r_q_data[i][r_wr_ptr[i]] <= unit_data[i*XLEN +: XLEN];
            end
        end
    end

    // Ready follows the post-edge count, so a full queue never advertises space.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_ready <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                r_count[i] <= w_count_next[i];
                r_ready[i] <= (w_count_next[i] < CW'(BUF_DEPTH));
            end
        end
    end

    // x0 is still released because the issuer may have locked it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
            rel_write   <= 1'b0;
            rel_address <= '0;
        end else begin
            rel_write <= w_grant_vld;
            rf_we     <= w_grant_vld && (w_head_rd != '0);
            if (w_grant_vld) begin
                rf_addr     <= w_head_rd;
                rf_data     <= w_head_data;
                rel_address <= w_head_rd;
                r_rr_ptr    <= (w_grant == PTR_W'(NUM_UNITS - 1)) ? '0 : w_grant + PTR_W'(1);
            end
        end
    end

    assign idle = ~|w_nonempty & ~rel_write;

endmodule

// File: tb/tb_writeback_commit.sv
// tb/tb_writeback_commit.sv - scoreboard bench for writeback_commit
module tb_writeback_commit;
    localparam int NU = 4;
    localparam int XL = 32;
    localparam int RW = 5;

    logic             clk;
    logic             rst_n;
    logic [NU-1:0]    unit_valid;
    logic [NU-1:0]    unit_ready;
    logic [NU*RW-1:0] unit_rd;
    logic [NU*XL-1:0] unit_data;
    logic             commit_en;
    logic             rf_we;
    logic [RW-1:0]    rf_addr;
    logic [XL-1:0]    rf_data;
    logic             rel_write;
    logic [RW-1:0]    rel_address;
    logic             idle;

    writeback_commit #(.NUM_UNITS(NU), .XLEN(XL), .REG_ADDR_W(RW), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .unit_valid(unit_valid), .unit_ready(unit_ready),
        .unit_rd(unit_rd), .unit_data(unit_data),
        .commit_en(commit_en),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .rel_write(rel_write), .rel_address(rel_address),
        .idle(idle)
    );

    typedef struct {
        int          unit;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    int   com_unit[$];
    int   com_rd[$];
    int   com_we[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done_a, done_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns just after the transfer edge; scoreboard entry recorded before it.
    task automatic drive_unit(input int u, input logic [4:0] rd, input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        unit_valid[u]          = 1'b1;
        unit_rd[u*RW +: RW]    = rd;
        unit_data[u*XL +: XL]  = data;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (unit_ready[u]) begin
                sb.push_back('{unit: u, rd: rd, data: data});
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 unit_valid[u] = 1'b0;
        if (!ok) check_eq("drive_timeout", 64'(u), 64'hFF);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (idle && sb.size() == 0) ok = 1'b1;
        end
        if (!ok) check_eq("idle_timeout", 64'(sb.size()), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_log();
        com_unit.delete();
        com_rd.delete();
        com_we.delete();
    endtask

    // Every commit must be the oldest pending entry of some unit.
    always @(negedge clk) begin
        if (rst_n && rel_write) begin
            bit found;
            found = 1'b0;
            for (int u = 0; u < NU && !found; u++) begin
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].unit == u) begin
                        if (sb[j].rd == rel_address && sb[j].data == rf_data) begin
                            found = 1'b1;
                            com_unit.push_back(u);
                            com_rd.push_back(int'(rel_address));
                            com_we.push_back(int'(rf_we));
                            sb.delete(j);
                        end
                        break;
                    end
                end
            end
            check_eq("commit_match", 64'(found), 64'h1);
            check_eq("rf_we_rule", 64'(rf_we), 64'(rel_address != 5'd0));
            check_eq("rf_addr_eq_rel", 64'(rf_addr), 64'(rel_address));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_units [8];
        rst_n = 1'b0; unit_valid = '0; unit_rd = '0; unit_data = '0; commit_en = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_rf_we", 64'(rf_we), 64'h0);
        check_eq("rst_rel_write", 64'(rel_write), 64'h0);
        check_eq("rst_rf_data", 64'(rf_data), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 64'(unit_ready), 64'hF);
        check_eq("rst_idle", 64'(idle), 64'h1);

        // single result, commit one cycle after grant
        clear_log();
        drive_unit(0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("t1_no_early", 64'(rel_write), 64'h0);
        @(negedge clk);
        check_eq("t1_rel_write", 64'(rel_write), 64'h1);
        check_eq("t1_rel_addr", 64'(rel_address), 64'd5);
        check_eq("t1_rf_we", 64'(rf_we), 64'h1);
        check_eq("t1_rf_addr", 64'(rf_addr), 64'd5);
        check_eq("t1_rf_data", 64'(rf_data), 64'hDEADBEEF);
        @(negedge clk);
        check_eq("t1_idle", 64'(idle), 64'h1);
        check_eq("t1_hold_addr", 64'(rf_addr), 64'd5);

        // four simultaneous pushes, pointer at 0
        do_reset();
        clear_log();
        fork
            drive_unit(0, 5'd1, 32'h0000_0101);
            drive_unit(1, 5'd2, 32'h0000_0202);
            drive_unit(2, 5'd3, 32'h0000_0303);
            drive_unit(3, 5'd4, 32'h0000_0404);
        join
        wait_idle();
        check_eq("t2_count", 64'(com_rd.size()), 64'd4);
        for (int k = 0; k < 4 && k < com_rd.size(); k++)
            check_eq("t2_order", 64'(com_rd[k]), 64'(k + 1));
        clear_log();
        fork
            drive_unit(1, 5'd7, 32'h0000_0707);
            drive_unit(0, 5'd8, 32'h0000_0808);
        join
        wait_idle();
        check_eq("t2_ptr_wrap", (com_unit.size() > 0) ? 64'(com_unit[0]) : 64'hEE, 64'd0);

        // x0 destination released without a register-file write
        clear_log();
        drive_unit(2, 5'd0, 32'h12);
        wait_idle();
        check_eq("t3_rd0", (com_rd.size() > 0) ? 64'(com_rd[0]) : 64'hEE, 64'd0);
        check_eq("t3_we0", (com_we.size() > 0) ? 64'(com_we[0]) : 64'hEE, 64'd0);

        // backpressure with commit held, then FIFO drain
        clear_log();
        commit_en = 1'b0;
        done_a = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) drive_unit(1, 5'(10 + k), 32'h1000 + 32'(k));
                done_a = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        check_eq("t4_ready_low", 64'(unit_ready[1]), 64'h0);
        check_eq("t4_accepted", 64'(sb.size()), 64'd2);
        check_eq("t4_no_commit", 64'(com_rd.size()), 64'd0);
        commit_en = 1'b1;
        for (int c = 0; c < 200 && !done_a; c++) @(negedge clk);
        wait_idle();
        check_eq("t4_count", 64'(com_rd.size()), 64'd3);
        for (int k = 0; k < 3 && k < com_rd.size(); k++)
            check_eq("t4_fifo", 64'(com_rd[k]), 64'(10 + k));

        // fairness between a saturated unit3 and a continuously fed unit0
        do_reset();
        clear_log();
        commit_en = 1'b0;
        done_a = 1'b0;
        done_b = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) drive_unit(3, 5'(20 + k), 32'h3000 + 32'(k));
                done_a = 1'b1;
            end
            begin
                for (int k = 0; k < 4; k++) drive_unit(0, 5'(24 + k), 32'h0000_5000 + 32'(k));
                done_b = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        commit_en = 1'b1;
        for (int c = 0; c < 200 && !(done_a && done_b); c++) @(negedge clk);
        wait_idle();
        exp_units = '{0, 3, 0, 3, 0, 3, 0, 3};
        check_eq("t5_count", 64'(com_unit.size()), 64'd8);
        for (int k = 0; k < 8 && k < com_unit.size(); k++)
            check_eq("t5_alternate", 64'(com_unit[k]), 64'(exp_units[k]));

        // reset with results queued discards them silently
        clear_log();
        commit_en = 1'b0;
        fork
            drive_unit(0, 5'd9, 32'hAAAA_0000);
            drive_unit(1, 5'd10, 32'hBBBB_0000);
            drive_unit(2, 5'd11, 32'hCCCC_0000);
        join
        @(negedge clk);
        check_eq("t6_busy", 64'(idle), 64'h0);
        rst_n = 1'b0;
        commit_en = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("t6_rst_rf_data", 64'(rf_data), 64'h0);
        check_eq("t6_rst_rf_addr", 64'(rf_addr), 64'h0);
        check_eq("t6_rst_rel_addr", 64'(rel_address), 64'h0);
        check_eq("t6_rst_rel_write", 64'(rel_write), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_ready", 64'(unit_ready), 64'hF);
        check_eq("t6_idle", 64'(idle), 64'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("t6_no_release", 64'(rel_write), 64'h0);
        end
        check_eq("t6_no_commits", 64'(com_rd.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
